// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator for the decode stage. Accepts one 32-bit
// RV32/RV64 instruction per cycle over a valid/ready handshake. One cycle
// later it presents:
//   - the XLEN-wide sign-extended immediate,
//   - a format code,
//   - an illegal-opcode flag.
// All outputs are registered.
//
// Parameters:
//   XLEN  32 or 64. Immediates sign-extend to this width.
//   SKID  1: two-entry skid buffer with a registered in_ready_o.
//         0: single output register, in_ready_o = !out_valid_o || out_ready_i.
//
// Optional feature (define IMM_GEN_ZIMM_EN):
//   Adds zimm_o, the zero-extended instr[19:15] field. It is non-zero only
//   for the CSR format and is registered alongside imm_o.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   flush_i      discard every held entry
//   in_valid_i   instruction valid
//   in_ready_o   block can accept
//   instr_i      32-bit instruction word
//   out_valid_o  result valid
//   out_ready_i  consumer accepts
//   imm_o        immediate, XLEN bits
//   fmt_o        0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR
//   illegal_o    opcode not in the decode list
//   zimm_o       CSR zimm field (only with IMM_GEN_ZIMM_EN)
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
`ifdef IMM_GEN_ZIMM_EN
  ,
  output logic [XLEN-1:0] zimm_o
`endif
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CSR  = 3'd6
  } fmt_e;

  // One decoded result: the payload of both the output and the skid registers.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
`ifdef IMM_GEN_ZIMM_EN
    logic [XLEN-1:0] zimm;
`endif
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  // Every format fits a 32-bit sign-extended value. It is built at 32 bits
  // first and then widened. w_imm32 is signed, so the size cast sign-extends
  // into bits XLEN-1:32 when XLEN is 64.
  logic signed [31:0] w_imm32;
  entry_t             w_dec;

  always_comb begin
    // NOTE: every variable gets a default before the case statement. Any path
    // that skips an assignment would otherwise infer a latch.
    w_imm32     = '0;
    w_dec       = '0;
    w_dec.fmt   = FMT_NONE;
    case (instr_i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        w_dec.fmt = FMT_I;
        w_imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      7'b0100011: begin
        w_dec.fmt = FMT_S;
        w_imm32   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      7'b0110111, 7'b0010111: begin
        w_dec.fmt = FMT_U;
        w_imm32   = {instr_i[31:12], 12'b0};
      end
      7'b1100011: begin
        w_dec.fmt = FMT_B;
        w_imm32   = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
      end
      7'b1101111: begin
        w_dec.fmt = FMT_J;
        w_imm32   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
      end
      7'b1110011: begin
        // The immediate is the CSR address.
        w_dec.fmt  = FMT_CSR;
        w_imm32    = {{20{instr_i[31]}}, instr_i[31:20]};
`ifdef IMM_GEN_ZIMM_EN
        w_dec.zimm = XLEN'(instr_i[19:15]);
`endif
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
    w_dec.imm = XLEN'(w_imm32);
  end

  // ---------------------------------------------------------------------------
  // Output register, shared by both buffering modes
  // ---------------------------------------------------------------------------
  entry_t r_out;
  logic   r_out_valid;

  assign out_valid_o = r_out_valid;
  assign imm_o       = r_out.imm;
  assign fmt_o       = r_out.fmt;
  assign illegal_o   = r_out.illegal;
`ifdef IMM_GEN_ZIMM_EN
  assign zimm_o      = r_out.zimm;
`endif

  generate
    if (SKID != 0) begin : g_skid
      // -----------------------------------------------------------------------
      // Two-entry skid buffer. in_ready_o comes from a register, so it has
      // no combinational path from out_ready_i.
      // -----------------------------------------------------------------------
      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
      } state_e;

      state_e r_state;
      state_e w_state_nxt;
      entry_t r_skid;
      logic   r_in_ready;
      logic   w_accept;
      logic   w_fire;
      logic   w_load_out_in;
      logic   w_load_out_skid;
      logic   w_load_skid;

      assign in_ready_o = r_in_ready;
      assign w_accept   = in_valid_i && r_in_ready;
      assign w_fire     = r_out_valid && out_ready_i;

      always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
          ST_EMPTY: begin
            if (w_accept) begin
              w_state_nxt   = ST_BUSY;
              w_load_out_in = 1'b1;
            end
          end
          ST_BUSY: begin
            if (w_accept && w_fire) begin
              // The old result leaves as the new one takes its place.
              w_load_out_in = 1'b1;
            end else if (w_accept) begin
              w_state_nxt = ST_FULL;
              w_load_skid = 1'b1;
            end else if (w_fire) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_FULL: begin
            // in_ready_o is low here, so an accept cannot happen.
            if (w_fire) begin
              w_state_nxt     = ST_BUSY;
              w_load_out_skid = 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_EMPTY;
          end
        endcase
        // Flush wins over a concurrent accept. An output fire in the same
        // cycle has already been taken by the consumer.
        if (flush_i) begin
          w_state_nxt     = ST_EMPTY;
          w_load_out_in   = 1'b0;
          w_load_out_skid = 1'b0;
          w_load_skid     = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        // NOTE: the data registers are reset as well as the valid bits. The
        // outputs then read zero after reset, and the entries are only two
        // registers wide, not a memory array.
        if (rst) begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_out       <= '0;
          r_skid      <= '0;
        end else begin
          // NOTE: non-blocking assignments. Every register samples its
          // pre-edge value, so this block does not depend on statement order.
          r_state     <= w_state_nxt;
          // Valid and ready are computed from the next state. Both are then
          // plain register outputs.
          r_out_valid <= (w_state_nxt != ST_EMPTY);
          r_in_ready  <= (w_state_nxt != ST_FULL);
          if (w_load_out_in) begin
            r_out <= w_dec;
          end else if (w_load_out_skid) begin
            r_out <= r_skid;
          end
          if (w_load_skid) begin
            r_skid <= w_dec;
          end
        end
      end
    end else begin : g_single
      // -----------------------------------------------------------------------
      // Single output register. Full throughput relies on the combinational
      // in_ready_o path from out_ready_i.
      // -----------------------------------------------------------------------
      logic w_accept;
      logic w_fire;

      assign in_ready_o = !r_out_valid || out_ready_i;
      assign w_accept   = in_valid_i && in_ready_o;
      assign w_fire     = r_out_valid && out_ready_i;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_valid <= 1'b0;
          r_out       <= '0;
        end else if (flush_i) begin
          r_out_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out       <= w_dec;
        end else if (w_fire) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
